// File: rtl/systolic_result_drain.sv
// Output-side drain for the skewed systolic array: waits out accumulation plus skew,
// snapshots the result matrix, then streams one row per valid/ready beat.
// Optional macro SYSTOLIC_DRAIN_SAT_OUT_EN: WIDTH-bit saturated elements plus sat_flag.
module systolic_result_drain #(
  parameter int WIDTH          = 16,
  parameter int HIDDEN_SIZE    = 64,
  parameter int CONTEXT_LENGTH = 128,
  parameter int KLEN_W         = 16,
  parameter int PIPE_LAT       = 1,
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  localparam int OUT_W         = WIDTH,
`else
  localparam int OUT_W         = 2*WIDTH,
`endif
  localparam int ROW_W         = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1
) (
  input  logic                                         clock,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [KLEN_W-1:0]                            k_len,
  input  logic [HIDDEN_SIZE*CONTEXT_LENGTH*2*WIDTH-1:0] Y_in,
  output logic                                         busy,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [CONTEXT_LENGTH*OUT_W-1:0]              out_data,
  output logic [ROW_W-1:0]                             out_row,
  output logic                                         out_last,
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  output logic                                         sat_flag,
`endif
  output logic                                         done
);

  localparam int ACC_W    = 2*WIDTH;
  localparam int ROW_BITS = CONTEXT_LENGTH*OUT_W;
  localparam int CNT_W    = KLEN_W + $clog2(HIDDEN_SIZE + CONTEXT_LENGTH + PIPE_LAT + 1) + 1;
  localparam logic [CNT_W-1:0] SKEW     = CNT_W'(HIDDEN_SIZE + CONTEXT_LENGTH + PIPE_LAT - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HIDDEN_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, CAPTURE, DRAIN} state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [ROW_W-1:0]                     row_q, row_d;
  logic                                 done_q, done_d;
  logic [HIDDEN_SIZE-1:0][ROW_BITS-1:0] snap_q;
  logic [HIDDEN_SIZE-1:0][ROW_BITS-1:0] capData;

`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [ACC_W-1:0] elem;
  logic                    anyClip;
  logic                    satFlag_q, satFlag_d;
`endif

  // Element j of row i sits at flat index i*CONTEXT_LENGTH+j of Y_in.
  always_comb begin
    capData = '0;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    anyClip = 1'b0;
    elem    = '0;
`endif
    for (int i = 0; i < HIDDEN_SIZE; i++) begin
      for (int j = 0; j < CONTEXT_LENGTH; j++) begin
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
        elem = Y_in[(i*CONTEXT_LENGTH+j)*ACC_W +: ACC_W];
        if (elem > SAT_MAX) begin
          capData[i][j*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
          anyClip = 1'b1;
        end else if (elem < SAT_MIN) begin
          capData[i][j*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
          anyClip = 1'b1;
        end else begin
          capData[i][j*OUT_W +: OUT_W] = elem[OUT_W-1:0];
        end
`else
        capData[i][j*OUT_W +: OUT_W] = Y_in[(i*CONTEXT_LENGTH+j)*ACC_W +: ACC_W];
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    satFlag_d = satFlag_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          cnt_d   = CNT_W'(k_len) + SKEW;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
          satFlag_d = 1'b0;
`endif
        end
      end
      COMPUTE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        row_d   = '0;
        state_d = DRAIN;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
        satFlag_d = satFlag_q | anyClip;
`endif
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
      satFlag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
      satFlag_q <= satFlag_d;
`endif
    end
  end

  // Snapshot lets the upstream array restart while rows are still draining.
  always_ff @(posedge clock) begin
    if (state_q == CAPTURE) snap_q <= capData;
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_row   = row_q;
  assign out_last  = (state_q == DRAIN) && (row_q == LAST_ROW);
  assign out_data  = snap_q[row_q];
  assign done      = done_q;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  assign sat_flag  = satFlag_q;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected rows are queued at start,
// a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_systolic_result_drain;

  localparam int WIDTH    = 16;
  localparam int H        = 4;
  localparam int C        = 4;
  localparam int KLEN_W   = 16;
  localparam int PIPE_LAT = 1;
  localparam int ACC_W    = 2*WIDTH;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  localparam int OUT_W    = WIDTH;
  localparam int SMAX     = (1 << (WIDTH-1)) - 1;
  localparam int SMIN     = -(1 << (WIDTH-1));
`else
  localparam int OUT_W    = ACC_W;
`endif
  localparam int ROW_W    = $clog2(H);
  localparam int MAX_WAIT = 2000;

  logic                   clock = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [KLEN_W-1:0]      k_len;
  logic [H*C*ACC_W-1:0]   Y_in;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [C*OUT_W-1:0]     out_data;
  logic [ROW_W-1:0]       out_row;
  logic                   out_last;
  logic                   done;
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  logic                   sat_flag;
  bit                     expSat;
`endif

  typedef struct {
    int                 row;
    logic [C*OUT_W-1:0] data;
    bit                 last;
  } exp_t;

  exp_t               expQ[$];
  int                 yMat[H][C];
  int                 checks = 0;
  int                 errors = 0;
  int                 cycleCnt = 0;
  int                 startEdge = 0;
  int                 readyMode = 0;
  bit                 readyPattern[6];
  bit                 pendingDone = 1'b0;
  bit                 prevStall = 1'b0;
  logic [C*OUT_W-1:0] prevData;
  logic [ROW_W-1:0]   prevRow;
  logic               prevLast;

  systolic_result_drain #(
    .WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .KLEN_W(KLEN_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .k_len(k_len), .Y_in(Y_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last),
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    .sat_flag(sat_flag),
`endif
    .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [C*ACC_W-1:0] actual,
                             input logic [C*ACC_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual timeout required event within %0d cycles", name, MAX_WAIT);
  endtask

  function automatic int clipVal(input int v);
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
`endif
    return v;
  endfunction

  function automatic logic [H*C*ACC_W-1:0] packY();
    logic [H*C*ACC_W-1:0] v;
    v = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++)
        v[(i*C+j)*ACC_W +: ACC_W] = ACC_W'(yMat[i][j]);
    return v;
  endfunction

  function automatic logic [C*OUT_W-1:0] modelRow(input int i);
    logic [C*OUT_W-1:0] r;
    r = '0;
    for (int j = 0; j < C; j++) r[j*OUT_W +: OUT_W] = OUT_W'(clipVal(yMat[i][j]));
    return r;
  endfunction

`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
  function automatic bit modelClips();
    bit any;
    any = 1'b0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++)
        if (clipVal(yMat[i][j]) != yMat[i][j]) any = 1'b1;
    return any;
  endfunction
`endif

  task automatic fillPattern();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++) yMat[i][j] = 16*i + j;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++) yMat[i][j] = int'($urandom);
  endtask

  task automatic syncDrive();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; start is sampled on the following edge.
  task automatic applyStimulus(input int kLen);
    exp_t e;
    Y_in  = packY();
    k_len = KLEN_W'(kLen);
    start = 1'b1;
    for (int i = 0; i < H; i++) begin
      e.row  = i;
      e.data = modelRow(i);
      e.last = (i == H-1);
      expQ.push_back(e);
    end
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    expSat = modelClips();
`endif
    @(posedge clock);
    #1;
    startEdge = cycleCnt;
    start     = 1'b0;
    checkOutput("busy after start", busy, 1);
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    checkOutput("sat_flag cleared on start", sat_flag, 0);
`endif
  endtask

  task automatic waitFirstValid(input int kLen, input bit corrupt);
    int n;
    n = 0;
    while (n < MAX_WAIT) begin
      @(negedge clock);
      if (out_valid) break;
      n++;
    end
    if (!out_valid) reportTimeout("first out_valid");
    else checkOutput("first-valid latency", cycleCnt - startEdge, kLen + H + C + PIPE_LAT - 1 + 2);
    if (corrupt) Y_in = {(H*C){32'hDEAD_BEEF}};
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (n < MAX_WAIT && (busy || expQ.size() != 0)) begin
      @(negedge clock);
      n++;
    end
    if (busy || expQ.size() != 0) reportTimeout("drain completion");
    @(negedge clock);
`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    checkOutput("sat_flag", sat_flag, expSat);
`endif
  endtask

  initial begin
    readyPattern[0] = 1'b1; readyPattern[1] = 1'b0; readyPattern[2] = 1'b0;
    readyPattern[3] = 1'b1; readyPattern[4] = 1'b0; readyPattern[5] = 1'b1;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = readyPattern[cycleCnt % 6];
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compares accepted beats, stall stability and the done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      prevStall   = 1'b0;
      pendingDone = 1'b0;
    end else begin
      checkOutput("done pulse", done, pendingDone);
      pendingDone = 1'b0;
      if (prevStall) begin
        checkOutput("valid held in stall", out_valid, 1);
        checkOutput("data held in stall", out_data, prevData);
        checkOutput("row held in stall", out_row, prevRow);
        checkOutput("last held in stall", out_last, prevLast);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected beat: actual row %0d required no beat", out_row);
        end else begin
          e = expQ.pop_front();
          checkOutput("row index", out_row, e.row);
          checkOutput("row data", out_data, e.data);
          checkOutput("out_last", out_last, e.last);
          if (e.last) pendingDone = 1'b1;
        end
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevRow   = out_row;
      prevLast  = out_last;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual still running required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int n;
    bit sawValid;
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    Y_in  = '0;
    #3;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset out_row", out_row, 0);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;

    $display("[TB] basic drain");
    readyMode = 0;
    fillPattern();
    syncDrive();
    applyStimulus(5);
    waitFirstValid(5, 1'b0);
    repeat (H) @(negedge clock);
    checkOutput("busy low after H beats", busy, 0);
    waitDone();

    $display("[TB] backpressure with snapshot isolation");
    readyMode = 1;
    syncDrive();
    applyStimulus(5);
    waitFirstValid(5, 1'b1);
    waitDone();

    $display("[TB] k_len zero");
    readyMode = 2;
    fillRandom();
    syncDrive();
    applyStimulus(0);
    waitFirstValid(0, 1'b0);
    waitDone();

    $display("[TB] start during drain");
    readyMode = 1;
    fillRandom();
    syncDrive();
    applyStimulus(7);
    waitFirstValid(7, 1'b0);
    syncDrive();
    start = 1'b1;
    k_len = KLEN_W'(3);
    syncDrive();
    start = 1'b0;
    checkOutput("busy after ignored start", busy, 1);
    waitDone();
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid || busy) sawValid = 1'b1;
    end
    checkOutput("ignored start left no operation", sawValid, 0);

    $display("[TB] start on done cycle");
    readyMode = 0;
    fillRandom();
    syncDrive();
    k = int'($urandom_range(0, 10));
    applyStimulus(k);
    waitFirstValid(k, 1'b0);
    n = 0;
    while (n < MAX_WAIT && !(out_valid && out_ready && out_last)) begin
      @(negedge clock);
      n++;
    end
    if (!(out_valid && out_ready && out_last)) reportTimeout("final beat");
    syncDrive();
    fillRandom();
    k = int'($urandom_range(0, 10));
    applyStimulus(k);
    waitFirstValid(k, 1'b0);
    waitDone();

    $display("[TB] reset mid-drain");
    readyMode = 0;
    fillRandom();
    syncDrive();
    applyStimulus(4);
    waitFirstValid(4, 1'b0);
    n = 0;
    while (n < MAX_WAIT && !(out_valid && out_ready && out_row == ROW_W'(1))) begin
      @(negedge clock);
      n++;
    end
    if (!(out_valid && out_ready && out_row == ROW_W'(1))) reportTimeout("row 1 accepted");
    @(posedge clock);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset out_row", out_row, 0);
    syncDrive();
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    fillRandom();
    syncDrive();
    applyStimulus(2);
    waitFirstValid(2, 1'b0);
    waitDone();

    $display("[TB] random operations");
    for (int t = 0; t < 6; t++) begin
      readyMode = 2;
      fillRandom();
      k = int'($urandom_range(0, 20));
      syncDrive();
      applyStimulus(k);
      waitFirstValid(k, 1'b0);
      waitDone();
    end

`ifdef SYSTOLIC_DRAIN_SAT_OUT_EN
    $display("[TB] saturation");
    readyMode = 0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++) yMat[i][j] = int'($urandom_range(0, 2000)) - 1000;
    yMat[0][0] = 70000;
    yMat[0][1] = -70000;
    syncDrive();
    applyStimulus(3);
    waitFirstValid(3, 1'b0);
    checkOutput("saturated high element", out_data[0 +: OUT_W], 16'sd32767);
    checkOutput("saturated low element", out_data[OUT_W +: OUT_W], 16'h8000);
    waitDone();
    checkOutput("sat_flag set", sat_flag, 1);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < C; j++) yMat[i][j] = int'($urandom_range(0, 2000)) - 1000;
    syncDrive();
    applyStimulus(1);
    waitFirstValid(1, 1'b0);
    waitDone();
`endif

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
